// File: rtl/req_ack_txn_ctrl_if.sv
// Handshake bundle between a request/acknowledge transaction controller and its environment.
interface req_ack_txn_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              start;
  logic [DATA_W-1:0] data_in;
  logic              ack;
  logic              ready;
  logic              req;
  logic              valid;
  logic [DATA_W-1:0] data_out;

  modport master (
    input  start, data_in, ack, ready,
    output req, valid, data_out
  );

  modport slave (
    output start, data_in, ack, ready,
    input  req, valid, data_out
  );
endinterface

// File: rtl/req_ack_txn_ctrl.sv
// Request/acknowledge transaction controller: start -> req until ack -> valid until ready,
// with ack timeout, completed-transaction counter and a registered rose(req)/ack/valid match flag.
module req_ack_txn_ctrl #(
  parameter int DATA_W      = 8,
  parameter int ACK_TIMEOUT = 4,
  parameter int CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  req_ack_txn_ctrl_if.master bus,
  output logic               busy,
  output logic               done,
  output logic               timeout_err,
  output logic               seq_hit,
  output logic [CNT_W-1:0]   txn_count
);

  localparam int WAIT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, VALID} state_t;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic              req_nxt, valid_nxt, done_nxt, tmo_nxt, cap_en;
  logic              req_p1, hit_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    req_nxt      = 1'b0;
    valid_nxt    = 1'b0;
    done_nxt     = 1'b0;
    tmo_nxt      = 1'b0;
    cap_en       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt    = REQ;
          req_nxt      = 1'b1;
          wait_cnt_nxt = '0;
          cap_en       = 1'b1;
        end
      end
      REQ: begin
        // ack is checked first so an ack on the last allowed cycle beats the timeout
        if (bus.ack) begin
          state_nxt = VALID;
          valid_nxt = 1'b1;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt = IDLE;
          tmo_nxt   = 1'b1;
        end else begin
          req_nxt      = 1'b1;
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end
      VALID: begin
        if (bus.ready) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          valid_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.req      <= 1'b0;
      bus.valid    <= 1'b0;
      bus.data_out <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      timeout_err  <= 1'b0;
      txn_count    <= '0;
    end else begin
      bus.req     <= req_nxt;
      bus.valid   <= valid_nxt;
      busy        <= (state_nxt != IDLE);
      done        <= done_nxt;
      timeout_err <= tmo_nxt;
      txn_count   <= txn_count + CNT_W'(done_nxt);
      if (cap_en) bus.data_out <= bus.data_in;
    end
  end

  // match history: hit_p1 marks a cycle where req just rose and ack was already high,
  // seq_hit fires the cycle after the valid that follows it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_p1  <= 1'b0;
      hit_p1  <= 1'b0;
      seq_hit <= 1'b0;
    end else begin
      req_p1  <= bus.req;
      hit_p1  <= bus.req & ~req_p1 & bus.ack;
      seq_hit <= hit_p1 & bus.valid;
    end
  end

endmodule
